// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared types and constants for the Life generation blocks
// Contents:
//   sched_state_t        generation scheduler state encoding
//   GEN_CNT_W            width of the completed-generation counter
//   DEFAULT_PERIOD       default run-mode generation period in cycles
//   DEFAULT_ACK_TIMEOUT  default cycles allowed for a bank compute acknowledge
package life_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_WAIT,
        S_STORE,
        S_FAULT
    } sched_state_t;

    localparam int GEN_CNT_W           = 16;
    localparam int DEFAULT_PERIOD      = 100000000;
    localparam int DEFAULT_ACK_TIMEOUT = 1024;

endpackage

// File: rtl/life_period_timer.sv
// rtl/life_period_timer.sv - saturating run-mode period timer
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous, active-high
//   clear    in   restart the count from zero (generation start)
//   elapsed  out  registered; high once the count has saturated at PERIOD-1
module life_period_timer
    import life_pkg::*;
#(
    parameter int PERIOD = DEFAULT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic elapsed
);

    localparam int              CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = (count == LAST) ? count : count + CNT_W'(1);
    end

    // elapsed tracks the value count is about to take, so it rises in the
    // same cycle the count reaches PERIOD-1 and run-mode starts land exactly
    // PERIOD cycles apart.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count   <= '0;
            elapsed <= 1'b0;
        end else begin
            count   <= count_next;
            elapsed <= (count_next == LAST);
        end
    end

endmodule

// File: rtl/life_gen_scheduler.sv
// rtl/life_gen_scheduler.sv - sequences one Life generation across the cell-array banks
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   cmd_run       level, free-running generations paced by PERIOD
//   cmd_step      pulse, start one generation from IDLE
//   bank_ack      pulse, datapath finished computing bank pos (honoured in WAIT only)
//   write_array   load bank pos from memory into the array (LOAD)
//   run           compute pulse for bank pos (COMPUTE)
//   write_mem     store bank pos from the array to memory (STORE)
//   pos           current bank index
//   busy          high outside IDLE and FAULT
//   gen_done      one-cycle pulse in the first IDLE cycle after the final STORE
//   gen_count     completed generations, wraps
//   fault         sticky acknowledge-timeout flag, cleared only by reset
module life_gen_scheduler
    import life_pkg::*;
#(
    parameter int   NUM_BANKS   = 4,
    parameter int   PERIOD      = DEFAULT_PERIOD,
    parameter int   ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT,
    localparam int  BANK_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_run,
    input  logic                 cmd_step,
    input  logic                 bank_ack,
    output logic                 write_array,
    output logic                 run,
    output logic                 write_mem,
    output logic [BANK_W-1:0]    pos,
    output logic                 busy,
    output logic                 gen_done,
    output logic [GEN_CNT_W-1:0] gen_count,
    output logic                 fault
);

    localparam int                WAIT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);
    localparam logic [BANK_W-1:0] LAST_POS  = BANK_W'(NUM_BANKS - 1);

    sched_state_t      state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              period_elapsed;
    logic              start;

    // cmd_step wins over run mode; either way exactly one generation starts.
    assign start = (state == S_IDLE) && (cmd_step || (cmd_run && period_elapsed));

    life_period_timer #(
        .PERIOD (PERIOD)
    ) u_period_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (start),
        .elapsed (period_elapsed)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            pos       <= '0;
            wait_cnt  <= '0;
            gen_count <= '0;
            gen_done  <= 1'b0;
        end else begin
            gen_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD;
                        pos   <= '0;
                    end
                end
                S_LOAD: begin
                    state <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    state    <= S_WAIT;
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    // An ack in the last allowed cycle still counts.
                    if (bank_ack) begin
                        state <= S_STORE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= S_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_STORE: begin
                    if (pos == LAST_POS) begin
                        state     <= S_IDLE;
                        pos       <= '0;
                        gen_count <= gen_count + GEN_CNT_W'(1);
                        gen_done  <= 1'b1;
                    end else begin
                        state <= S_LOAD;
                        pos   <= pos + BANK_W'(1);
                    end
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes are pure decodes of the registered state, so they are mutually
    // exclusive and vanish the cycle after a reset edge.
    assign write_array = (state == S_LOAD);
    assign run         = (state == S_COMPUTE);
    assign write_mem   = (state == S_STORE);
    assign busy        = (state != S_IDLE) && (state != S_FAULT);
    assign fault       = (state == S_FAULT);

endmodule

// File: tb/tb_life_gen_scheduler.sv
// tb/tb_life_gen_scheduler.sv - scoreboard bench for life_gen_scheduler
module tb_life_gen_scheduler;

    localparam int NB     = 4;
    localparam int P      = 40;
    localparam int AT     = 8;
    localparam int NO_ACK = 255;

    localparam int EV_LOAD  = 1;
    localparam int EV_RUN   = 2;
    localparam int EV_STORE = 3;
    localparam int EV_DONE  = 4;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        cmd_run   = 1'b0;
    logic        cmd_step  = 1'b0;
    logic        dp_ack    = 1'b0;
    logic        stray_ack = 1'b0;
    logic        bank_ack;
    logic        write_array;
    logic        run;
    logic        write_mem;
    logic [1:0]  pos;
    logic        busy;
    logic        gen_done;
    logic [15:0] gen_count;
    logic        fault;

    assign bank_ack = dp_ack | stray_ack;

    int cyc       = 0;
    int checks    = 0;
    int errors    = 0;
    int exp_gc    = 0;
    int last_load = 0;
    int dly[NB];

    typedef struct {
        int kind;
        int pos;
        int cyc;
        int gc;
    } ev_t;

    ev_t exp_q[$];

    life_gen_scheduler #(
        .NUM_BANKS   (NB),
        .PERIOD      (P),
        .ACK_TIMEOUT (AT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_run     (cmd_run),
        .cmd_step    (cmd_step),
        .bank_ack    (bank_ack),
        .write_array (write_array),
        .run         (run),
        .write_mem   (write_mem),
        .pos         (pos),
        .busy        (busy),
        .gen_done    (gen_done),
        .gen_count   (gen_count),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void push_ev(input int kind, input int p, input int c, input int gc);
        ev_t e;
        e.kind = kind;
        e.pos  = p;
        e.cyc  = c;
        e.gc   = gc;
        exp_q.push_back(e);
    endfunction

    // Reference model of one generation whose first LOAD is in cycle t0:
    // each bank spends LOAD, COMPUTE, 1+delay WAIT cycles and STORE.
    task automatic push_gen(input int t0, output int done_c);
        int t;
        t      = t0;
        done_c = -1;
        for (int b = 0; b < NB; b++) begin
            push_ev(EV_LOAD, b, t, 0);
            push_ev(EV_RUN, b, t + 1, 0);
            if (dly[b] == NO_ACK) return;
            push_ev(EV_STORE, b, t + 3 + dly[b], 0);
            t += 4 + dly[b];
        end
        exp_gc = (exp_gc + 1) & 16'hffff;
        push_ev(EV_DONE, 0, t, exp_gc);
        done_c = t;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset     = 1'b0;
        last_load = cyc;
        exp_gc    = 0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy", int'(busy), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_gen_done", int'(gen_done), 0);
        chk("rst_pos", int'(pos), 0);
        chk("rst_gen_count", int'(gen_count), 0);
        chk("rst_strobes", int'(write_array) + int'(run) + int'(write_mem), 0);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0) && k < 400) begin
            tick();
            k++;
        end
        if (k >= 400) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy=%0d pending=%0d after %0d cycles, expected idle", busy, exp_q.size(), k);
            exp_q.delete();
        end
        tick();
    endtask

    task automatic step_gen();
        int n;
        int dc;
        n = cyc;
        cmd_step = 1'b1;
        push_gen(n + 1, dc);
        last_load = n + 1;
        tick();
        cmd_step = 1'b0;
    endtask

    // Datapath model: acknowledge dly[pos] cycles into WAIT.
    initial begin : datapath
        int d;
        forever begin
            @(negedge clk);
            if (run === 1'b1 && !reset) begin
                d = dly[pos];
                if (d != NO_ACK) begin
                    repeat (d + 1) @(posedge clk);
                    #1 dp_ack = 1'b1;
                    @(posedge clk);
                    #1 dp_ack = 1'b0;
                end
            end
        end
    end

    // Monitor: every strobe or gen_done pops one expected event.
    initial begin : monitor
        int   nh;
        int   kind;
        ev_t  e;
        forever begin
            @(negedge clk);
            nh   = 0;
            kind = 0;
            if (write_array === 1'b1) begin nh++; kind = EV_LOAD;  end
            if (run === 1'b1)         begin nh++; kind = EV_RUN;   end
            if (write_mem === 1'b1)   begin nh++; kind = EV_STORE; end
            if (gen_done === 1'b1)    begin nh++; kind = EV_DONE;  end
            if (nh > 1) chk("one_event_per_cycle", nh, 1);
            if (kind != 0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: kind %0d pos %0d at cycle %0d, expected none", kind, pos, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_kind", kind, e.kind);
                    chk("ev_pos", int'(pos), e.pos);
                    chk("ev_cycle", cyc, e.cyc);
                    if (kind == EV_DONE) chk("gen_count", int'(gen_count), e.gc);
                end
            end
        end
    end

    initial begin : main
        int n;
        int r;
        int c;
        int l1;
        int l2;
        int l3;
        int d1;
        int d2;
        int d3;

        for (int b = 0; b < NB; b++) dly[b] = 0;
        do_reset(3);
        check_reset_outputs();

        // Single step, immediate acks: gen_done 17 cycles after cmd_step.
        step_gen();
        wait_idle();

        // Slow ack on bank 2.
        dly[2] = 5;
        step_gen();
        wait_idle();

        // cmd_step while busy and a stray ack in LOAD are ignored.
        dly[0] = 2; dly[1] = 0; dly[2] = 0; dly[3] = 1;
        step_gen();
        cmd_step  = 1'b1;
        stray_ack = 1'b1;
        tick();
        cmd_step  = 1'b0;
        stray_ack = 1'b0;
        repeat (5) tick();
        cmd_step = 1'b1;
        tick();
        cmd_step = 1'b0;
        wait_idle();

        // Randomized ack delays (up to the last allowed WAIT cycle) with
        // dropped cmd_step pulses mid-generation.
        repeat (6) begin
            for (int b = 0; b < NB; b++) dly[b] = $urandom_range(0, AT - 1);
            step_gen();
            repeat ($urandom_range(1, 10)) tick();
            cmd_step = 1'b1;
            tick();
            cmd_step = 1'b0;
            wait_idle();
        end

        // Run mode: starts are max(P, generation length + 1) apart.
        for (int b = 0; b < NB; b++) dly[b] = 0;
        r = cyc;
        cmd_run = 1'b1;
        c  = (r > last_load + P - 1) ? r : last_load + P - 1;
        l1 = c + 1;
        push_gen(l1, d1);
        c  = (d1 > l1 + P - 1) ? d1 : l1 + P - 1;
        l2 = c + 1;
        push_gen(l2, d2);
        c  = (d2 > l2 + P - 1) ? d2 : l2 + P - 1;
        l3 = c + 1;
        push_gen(l3, d3);
        last_load = l3;
        while (cyc < l3 + 2) tick();
        cmd_run = 1'b0;
        wait_idle();
        repeat (P + 5) tick();
        chk("run_gen_count", int'(gen_count), exp_gc);

        // Reset with cmd_run held: first start P cycles after release.
        cmd_run = 1'b1;
        do_reset(3);
        push_gen(last_load + P, d1);
        last_load = last_load + P;
        while (cyc < last_load + 2) tick();
        cmd_run = 1'b0;
        wait_idle();

        // Reset during WAIT of bank 1.
        dly[1] = NO_ACK;
        n = cyc;
        step_gen();
        while (cyc < n + 8) tick();
        chk("wait_busy", int'(busy), 1);
        chk("wait_pending", exp_q.size(), 0);
        reset = 1'b1;
        tick();
        check_reset_outputs();
        reset     = 1'b0;
        last_load = cyc;
        exp_gc    = 0;
        repeat (3) tick();
        chk("post_reset_busy", int'(busy), 0);

        // Ack timeout on bank 0.
        for (int b = 0; b < NB; b++) dly[b] = 0;
        dly[0] = NO_ACK;
        n = cyc;
        step_gen();
        while (cyc < n + 10) tick();
        chk("last_wait_fault", int'(fault), 0);
        chk("last_wait_busy", int'(busy), 1);
        tick();
        chk("fault_set", int'(fault), 1);
        chk("fault_busy", int'(busy), 0);
        chk("fault_strobes", int'(write_array) + int'(run) + int'(write_mem), 0);
        cmd_step = 1'b1;
        tick();
        cmd_step = 1'b0;
        repeat (10) tick();
        chk("fault_sticky", int'(fault), 1);
        chk("fault_step_ignored", int'(busy), 0);
        do_reset(2);
        check_reset_outputs();

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
